// File: rtl/sum_accumulator.sv
// Accumulates SAMPLES 4-bit sums into a saturating ACC_WIDTH total,
// then holds the result until downstream takes it.
module sum_accumulator #(
    parameter int SAMPLES   = 4,
    parameter int ACC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [3:0]           i_sum_state,
    input  logic                 i_sum_valid,
    output logic                 o_sum_ready,
    output logic [ACC_WIDTH-1:0] o_result,
    output logic                 o_result_valid,
    input  logic                 i_result_ready,
    output logic                 o_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [7:0] LAST = 8'(SAMPLES);

    state_t               state;
    state_t               state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [7:0]           count;
    logic [7:0]           count_nxt;
    logic                 flag;
    logic                 flag_nxt;
    logic                 accept;
    logic [ACC_WIDTH:0]   sum;

    assign o_sum_ready = (state != HOLD);
    assign accept      = i_sum_valid && o_sum_ready;
    // One spare bit catches the carry that triggers saturation.
    assign sum = {1'b0, acc} + {{(ACC_WIDTH-3){1'b0}}, i_sum_state};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            flag  <= flag_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        flag_nxt  = flag;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = ACC_WIDTH'(i_sum_state);
                    count_nxt = 8'd1;
                    state_nxt = (LAST == 8'd1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (sum[ACC_WIDTH]) begin
                        acc_nxt  = '1;
                        flag_nxt = 1'b1;
                    end else begin
                        acc_nxt = sum[ACC_WIDTH-1:0];
                    end
                    count_nxt = count + 8'd1;
                    if (count_nxt == LAST) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (i_result_ready) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    count_nxt = '0;
                    flag_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs derive from the registered state, so valid lags the last sample by one cycle.
    assign o_result_valid = (state == HOLD);
    assign o_result       = o_result_valid ? acc : '0;
    assign o_overflow     = o_result_valid && flag;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: default and 5-bit instances share stimulus,
// a reference model pushes expected totals into a scoreboard queue.
module tb_sum_accumulator;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_sum_state = 4'd0;
    logic       i_sum_valid = 1'b0;
    logic       i_result_ready = 1'b0;

    logic       rdy8, vld8, ovf8;
    logic [7:0] res8;
    logic       rdy5, vld5, ovf5;
    logic [4:0] res5;

    int errors = 0;
    int checks = 0;

    int exp_q[$];
    bit m_hold = 1'b0;
    int m_sum = 0;
    int m_cnt = 0;

    always #5 i_clk = ~i_clk;

    sum_accumulator dut8 (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sum_state    (i_sum_state),
        .i_sum_valid    (i_sum_valid),
        .o_sum_ready    (rdy8),
        .o_result       (res8),
        .o_result_valid (vld8),
        .i_result_ready (i_result_ready),
        .o_overflow     (ovf8)
    );

    sum_accumulator #(.SAMPLES(4), .ACC_WIDTH(5)) dut5 (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sum_state    (i_sum_state),
        .i_sum_valid    (i_sum_valid),
        .o_sum_ready    (rdy5),
        .o_result       (res5),
        .o_result_valid (vld5),
        .i_result_ready (i_result_ready),
        .o_overflow     (ovf5)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int s, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (s > mx) ? mx : s;
    endfunction

    task automatic compare();
        int e;
        e = (m_hold && exp_q.size() > 0) ? exp_q[0] : 0;
        check("rdy8", int'(rdy8), int'(!m_hold));
        check("vld8", int'(vld8), int'(m_hold));
        check("res8", int'(res8), m_hold ? sat(e, 8) : 0);
        check("ovf8", int'(ovf8), int'(m_hold && e > 255));
        check("rdy5", int'(rdy5), int'(!m_hold));
        check("vld5", int'(vld5), int'(m_hold));
        check("res5", int'(res5), m_hold ? sat(e, 5) : 0);
        check("ovf5", int'(ovf5), int'(m_hold && e > 31));
    endtask

    task automatic tick(input logic rst, input logic v,
                        input logic [3:0] s, input logic rr);
        @(negedge i_clk);
        i_rst          = rst;
        i_sum_valid    = v;
        i_sum_state    = s;
        i_result_ready = rr;
        @(posedge i_clk);
        if (rst) begin
            m_hold = 1'b0;
            m_sum  = 0;
            m_cnt  = 0;
            exp_q.delete();
        end else if (m_hold) begin
            if (rr) begin
                m_hold = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (v) begin
            m_sum += int'(s);
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back(m_sum);
                m_hold = 1'b1;
                m_sum  = 0;
                m_cnt  = 0;
            end
        end
        #1;
        compare();
    endtask

    initial begin
        // reset for two cycles
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("rst_rdy", int'(rdy8), 1);
        check("rst_vld", int'(vld8), 0);
        check("rst_res", int'(res8), 0);
        check("rst_ovf", int'(ovf8), 0);

        // back-to-back 3,5,7,9
        tick(0, 1, 3, 1);
        tick(0, 1, 5, 1);
        tick(0, 1, 7, 1);
        tick(0, 1, 9, 1);
        check("b2b_vld", int'(vld8), 1);
        check("b2b_res", int'(res8), 24);
        check("b2b_ovf", int'(ovf8), 0);
        tick(0, 0, 0, 1);
        check("b2b_one", int'(vld8), 0);

        // gapped 1,-,2,-,-,3,4
        tick(0, 1, 1, 1);
        tick(0, 0, 9, 1);
        tick(0, 1, 2, 1);
        tick(0, 0, 9, 1);
        tick(0, 0, 9, 1);
        tick(0, 1, 3, 1);
        tick(0, 1, 4, 0);
        check("gap_res", int'(res8), 10);
        tick(0, 0, 0, 1);

        // backpressure with ignored samples
        tick(0, 1, 3, 0);
        tick(0, 1, 5, 0);
        tick(0, 1, 7, 0);
        tick(0, 1, 9, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 15, 0);
            check("bp_hold", int'(res8), 24);
            check("bp_rdy", int'(rdy8), 0);
        end
        tick(0, 1, 15, 1);
        check("bp_xfer", int'(vld8), 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 2, 0);
        check("bp_next", int'(res8), 8);
        tick(0, 0, 0, 1);

        // saturation
        for (int i = 0; i < 4; i++) tick(0, 1, 15, 0);
        check("sat_res5", int'(res5), 31);
        check("sat_ovf5", int'(ovf5), 1);
        check("sat_res8", int'(res8), 60);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 0);
        check("sat2_res5", int'(res5), 4);
        check("sat2_ovf5", int'(ovf5), 0);
        tick(0, 0, 0, 1);

        // reset mid-accumulation, with a simultaneous sample
        tick(0, 1, 7, 1);
        tick(0, 1, 7, 1);
        tick(1, 1, 7, 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 0);
        check("rmid_res", int'(res8), 4);

        // reset mid-hold overrides a transfer
        tick(1, 0, 0, 1);
        check("rhold_vld", int'(vld8), 0);
        tick(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
